// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
//   Shares one memory port between NUM_REQ requesters (0 = CPU core,
//   1 = DMA, 2 = host/debug). Round-robin grant, one outstanding transaction,
//   variable-latency memory completion through i_mem_ack.
//
//   FSM: IDLE -> ISSUE -> BUSY -> DONE -> IDLE. All outputs are registered.
//   A zero-wait memory gives done three cycles after req is seen, so each
//   transaction takes at least four cycles.
//
//   Optional feature macro: BUS_ARB_TIMEOUT_EN
//     defined   - BUSY aborts after TIMEOUT_CYCLES cycles without i_mem_ack;
//                 the requester gets done together with o_err, rdata = all ones.
//     undefined - BUSY waits for i_mem_ack forever, o_err is tied low.
//
// Ports
//   i_clk, i_rst_n    clock, asynchronous active-low reset
//   i_req/i_we        per-requester request / write enable
//   i_addr/i_wdata    packed per-requester address / write data
//   o_done            one-cycle completion pulse to the granted requester
//   o_rdata           read data, valid in the done cycle of a read
//   o_busy            high in ISSUE/BUSY/DONE
//   o_grant_id        index of the current/last winner
//   o_err             abort pulse, coincident with done (timeout build only)
//   o_mem_*           memory request side, held stable until i_mem_ack
//   i_mem_rdata/ack   memory response
// ---------------------------------------------------------------------------
module bus_arbiter #(
    parameter int unsigned NUM_REQ        = 3,
    parameter int unsigned AW             = 16,
    parameter int unsigned DW             = 8,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [NUM_REQ-1:0]    i_req,
    input  logic [NUM_REQ-1:0]    i_we,
    input  logic [NUM_REQ*AW-1:0] i_addr,
    input  logic [NUM_REQ*DW-1:0] i_wdata,
    output logic [NUM_REQ-1:0]    o_done,
    output logic [DW-1:0]         o_rdata,
    output logic                  o_busy,
    output logic [2:0]            o_grant_id,
    output logic                  o_err,
    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic [AW-1:0]         o_mem_addr,
    output logic [DW-1:0]         o_mem_wdata,
    input  logic [DW-1:0]         i_mem_rdata,
    input  logic                  i_mem_ack
);

    // Index width for a requester number; one extra bit for the wrap sum.
    localparam int unsigned IW = $clog2(NUM_REQ);
    localparam int unsigned CW = IW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_BUSY  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    logic [IW-1:0]       r_ptr;
    logic [IW-1:0]       r_grant;
    logic [NUM_REQ-1:0]  r_done;
    logic [DW-1:0]       r_rdata;
    logic                r_busy;
    logic                r_mem_req;
    logic                r_mem_we;
    logic [AW-1:0]       r_mem_addr;
    logic [DW-1:0]       r_mem_wdata;

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] r_to_cnt;
    logic          r_err;
`endif

    // Round-robin pick: first asserted request at or after r_ptr, wrapping.
    logic          w_found;
    logic [IW-1:0] w_win;
    logic [CW-1:0] w_idx;

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = {1'b0, r_ptr} + CW'(i);
            if (w_idx >= CW'(NUM_REQ))
                w_idx = w_idx - CW'(NUM_REQ);
            if (!w_found && i_req[w_idx[IW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[IW-1:0];
            end
        end
    end

    logic [IW-1:0] w_ptr_next;
    assign w_ptr_next = (r_grant == IW'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_grant     <= '0;
            r_done      <= '0;
            r_rdata     <= '0;
            r_busy      <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
`ifdef BUS_ARB_TIMEOUT_EN
            r_to_cnt    <= '0;
            r_err       <= 1'b0;
`endif
        end else begin
            // done/err are single-cycle pulses
            r_done <= '0;
`ifdef BUS_ARB_TIMEOUT_EN
            r_err  <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant     <= w_win;
                        r_mem_we    <= i_we[w_win];
                        r_mem_addr  <= i_addr[w_win*AW +: AW];
                        r_mem_wdata <= i_wdata[w_win*DW +: DW];
                        // mem_req is raised now so it is visible in ISSUE
                        r_mem_req   <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= S_ISSUE;
`ifdef BUS_ARB_TIMEOUT_EN
                        r_to_cnt    <= '0;
`endif
                    end
                end

                S_ISSUE: r_state <= S_BUSY;

                S_BUSY: begin
                    // Leaving BUSY on the first ack means later acks are ignored.
                    if (i_mem_ack) begin
                        if (!r_mem_we)
                            r_rdata <= i_mem_rdata;
                        r_mem_req       <= 1'b0;
                        r_done[r_grant] <= 1'b1;
                        r_state         <= S_DONE;
                    end
`ifdef BUS_ARB_TIMEOUT_EN
                    else if (r_to_cnt == TO_LAST) begin
                        r_rdata         <= '1;
                        r_err           <= 1'b1;
                        r_mem_req       <= 1'b0;
                        r_done[r_grant] <= 1'b1;
                        r_state         <= S_DONE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
`endif
                end

                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_ptr   <= w_ptr_next;
                    r_state <= S_IDLE;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef BUS_ARB_TIMEOUT_EN
    assign o_err = r_err;
`else
    assign o_err = 1'b0;
    // TIMEOUT_CYCLES only matters when the timeout build is selected.
    if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
    end
`endif

    assign o_done      = r_done;
    assign o_rdata     = r_rdata;
    assign o_busy      = r_busy;
    assign o_grant_id  = 3'(r_grant);
    assign o_mem_req   = r_mem_req;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter. Timing reference: "c0" is the cycle in
// which a request is presented; outputs are sampled 1 time unit after each
// rising edge, inputs are driven at the same point.
module tb_bus_arbiter;

    localparam int NR = 3;
    localparam int AW = 16;
    localparam int DW = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NR-1:0]     req = '0;
    logic [NR-1:0]     we = '0;
    logic [NR*AW-1:0]  addr = '0;
    logic [NR*DW-1:0]  wdata = '0;
    logic [NR-1:0]     done;
    logic [DW-1:0]     rdata;
    logic              busy;
    logic [2:0]        grant_id;
    logic              err;
    logic              mem_req;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata = '0;
    logic              mem_ack = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bus_arbiter #(.NUM_REQ(NR), .AW(AW), .DW(DW), .TIMEOUT_CYCLES(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_we(we), .i_addr(addr),
        .i_wdata(wdata), .o_done(done), .o_rdata(rdata), .o_busy(busy),
        .o_grant_id(grant_id), .o_err(err), .o_mem_req(mem_req),
        .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .i_mem_rdata(mem_rdata), .i_mem_ack(mem_ack)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        tick;
        tick;
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_mem_req: got %0h want 0", mem_req); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %0h want 0", busy); end
        total++; if (done !== 3'b000) begin bad++; $display("FAIL rst_done: got %0h want 0", done); end
        total++; if ({grant_id, err, rdata, mem_we, mem_addr, mem_wdata} !== '0) begin
            bad++; $display("FAIL rst_others: got %0h want 0", {grant_id, err, rdata, mem_we, mem_addr, mem_wdata});
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_single_read;
        req = 3'b001; we = 3'b000; addr[15:0] = 16'hC000;
        tick; // c1 ISSUE
        total++; if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 16'hC000}) begin
            bad++; $display("FAIL rd_issue: got %0h want %0h", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 16'hC000});
        end
        total++; if ({busy, grant_id, done} !== {1'b1, 3'd0, 3'b000}) begin
            bad++; $display("FAIL rd_issue_ctl: got %0h want %0h", {busy, grant_id, done}, {1'b1, 3'd0, 3'b000});
        end
        tick; // c2 BUSY, zero-wait ack
        mem_ack = 1'b1; mem_rdata = 8'h3C;
        total++; if ({mem_req, done} !== {1'b1, 3'b000}) begin
            bad++; $display("FAIL rd_busy: got %0h want %0h", {mem_req, done}, {1'b1, 3'b000});
        end
        tick; // c3 DONE
        mem_ack = 1'b0; mem_rdata = 8'h00;
        total++; if (done !== 3'b001) begin bad++; $display("FAIL rd_done: got %0h want 1", done); end
        total++; if (rdata !== 8'h3C) begin bad++; $display("FAIL rd_rdata: got %0h want 3c", rdata); end
        total++; if ({mem_req, busy, err} !== 3'b010) begin
            bad++; $display("FAIL rd_done_ctl: got %0h want 2", {mem_req, busy, err});
        end
        req = 3'b000;
        tick; // c4 IDLE
        total++; if ({done, busy} !== 4'b0000) begin bad++; $display("FAIL rd_idle: got %0h want 0", {done, busy}); end
    endtask

    task automatic test_write_wait;
        int n_req = 0;
        int n_done = 0;
        req = 3'b010; we = 3'b010; addr[31:16] = 16'hFF46; wdata[15:8] = 8'hA5;
        for (int c = 1; c <= 7; c++) begin
            tick;
            if (mem_req === 1'b1) n_req++;
            if (done !== 3'b000) n_done++;
            if (c == 1) begin
                total++; if ({mem_we, mem_wdata, mem_addr, grant_id} !== {1'b1, 8'hA5, 16'hFF46, 3'd1}) begin
                    bad++; $display("FAIL wr_issue: got %0h want %0h", {mem_we, mem_wdata, mem_addr, grant_id}, {1'b1, 8'hA5, 16'hFF46, 3'd1});
                end
            end
            mem_ack   = (c == 6);
            mem_rdata = (c == 6) ? 8'h77 : 8'h00;
            if (c == 7) begin
                total++; if (done !== 3'b010) begin bad++; $display("FAIL wr_done: got %0h want 2", done); end
                total++; if (rdata !== 8'h3C) begin bad++; $display("FAIL wr_rdata_kept: got %0h want 3c", rdata); end
                total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL wr_req_drop: got %0h want 0", mem_req); end
                req = 3'b000; we = 3'b000;
            end
        end
        total++; if (n_req != 6) begin bad++; $display("FAIL wr_req_cycles: got %0d want 6", n_req); end
        total++; if (n_done != 1) begin bad++; $display("FAIL wr_done_count: got %0d want 1", n_done); end
        tick;
    endtask

    task automatic test_contention;
        int order [4] = '{0, 1, 2, 0};
        int n = 0;
        logic [2:0] want;
        // pointer back to 0
        rst_n = 1'b0; #3; rst_n = 1'b1;
        req = 3'b111; we = 3'b000;
        addr = {16'h2222, 16'h1111, 16'h0000};
        for (int t = 1; t <= 16; t++) begin
            tick;
            mem_ack   = (t % 4 == 2);
            mem_rdata = 8'(t);
            if (t % 4 == 1) begin
                total++; if ({grant_id, mem_addr} !== {3'(order[(t-1)/4]), 16'(order[(t-1)/4] * 16'h1111)}) begin
                    bad++; $display("FAIL rr_grant_t%0d: got %0h want %0h", t, {grant_id, mem_addr}, {3'(order[(t-1)/4]), 16'(order[(t-1)/4] * 16'h1111)});
                end
            end
            if (done !== 3'b000) begin
                want = (n < 4) ? 3'(1 << order[n]) : 3'b000;
                total++; if (done !== want) begin bad++; $display("FAIL rr_done_%0d: got %0h want %0h", n, done, want); end
                n++;
            end
        end
        req = 3'b000; mem_ack = 1'b0;
        total++; if (n != 4) begin bad++; $display("FAIL rr_done_count: got %0d want 4", n); end
        tick;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rr_idle: got %0h want 0", busy); end
    endtask

    task automatic test_ack_ignored;
        mem_ack = 1'b1; mem_rdata = 8'hEE; // ack in IDLE, nothing pending
        tick;
        mem_ack = 1'b0;
        total++; if ({busy, mem_req, done} !== 5'b0) begin
            bad++; $display("FAIL ack_idle: got %0h want 0", {busy, mem_req, done});
        end
        req = 3'b001; addr[15:0] = 16'h1234;
        tick; // c1 ISSUE: ack here must be ignored; requester drops req early
        mem_ack = 1'b1; mem_rdata = 8'hEE; req = 3'b000;
        tick; // c2 BUSY
        mem_ack = 1'b0;
        total++; if ({mem_req, done} !== {1'b1, 3'b000}) begin
            bad++; $display("FAIL ack_issue_ignored: got %0h want %0h", {mem_req, done}, {1'b1, 3'b000});
        end
        tick; // c3 BUSY
        mem_ack = 1'b1; mem_rdata = 8'h5A;
        tick; // c4 DONE; ack stays high, must not count again
        mem_rdata = 8'h99;
        total++; if ({done, rdata} !== {3'b001, 8'h5A}) begin
            bad++; $display("FAIL ack_drop_done: got %0h want %0h", {done, rdata}, {3'b001, 8'h5A});
        end
        tick; // c5 IDLE
        mem_ack = 1'b0;
        total++; if ({done, busy, rdata} !== {3'b000, 1'b0, 8'h5A}) begin
            bad++; $display("FAIL ack_extra: got %0h want %0h", {done, busy, rdata}, {3'b000, 1'b0, 8'h5A});
        end
    endtask

    task automatic test_reset_midop;
        req = 3'b010;
        tick; tick; // BUSY, grant 1
        total++; if ({mem_req, busy} !== 2'b11) begin bad++; $display("FAIL mid_pre: got %0h want 3", {mem_req, busy}); end
        #2; rst_n = 1'b0; #1;
        total++; if ({mem_req, busy, done, grant_id, mem_addr} !== '0) begin
            bad++; $display("FAIL mid_async: got %0h want 0", {mem_req, busy, done, grant_id, mem_addr});
        end
        req = 3'b100;
        @(negedge clk);
        rst_n = 1'b1;
        tick; // ISSUE
        total++; if ({grant_id, mem_req, done} !== {3'd2, 1'b1, 3'b000}) begin
            bad++; $display("FAIL mid_regrant: got %0h want %0h", {grant_id, mem_req, done}, {3'd2, 1'b1, 3'b000});
        end
        tick; mem_ack = 1'b1; mem_rdata = 8'h42;
        tick; mem_ack = 1'b0;
        total++; if (done !== 3'b100) begin bad++; $display("FAIL mid_done: got %0h want 4", done); end
        req = 3'b000;
        tick;
        // Leave the pointer at 1, then reset: requests 0 and 2 must pick 0.
        req = 3'b001;
        tick; tick; mem_ack = 1'b1;
        tick; mem_ack = 1'b0; req = 3'b000;
        tick;
        rst_n = 1'b0; #2; rst_n = 1'b1;
        req = 3'b101;
        tick;
        total++; if (grant_id !== 3'd0) begin bad++; $display("FAIL mid_ptr_reset: got %0h want 0", grant_id); end
        tick; mem_ack = 1'b1;
        tick; mem_ack = 1'b0; req = 3'b000;
        total++; if (done !== 3'b001) begin bad++; $display("FAIL mid_ptr_done: got %0h want 1", done); end
        tick;
    endtask

    task automatic test_timeout;
        req = 3'b001; we = 3'b000; addr[15:0] = 16'hBEEF;
`ifdef BUS_ARB_TIMEOUT_EN
        begin
            int n_req = 0;
            for (int c = 1; c <= 8; c++) begin
                tick;
                if (mem_req === 1'b1) n_req++;
                if (c == 6) begin
                    total++; if ({done, err, rdata, mem_req} !== {3'b001, 1'b1, 8'hFF, 1'b0}) begin
                        bad++; $display("FAIL to_abort: got %0h want %0h", {done, err, rdata, mem_req}, {3'b001, 1'b1, 8'hFF, 1'b0});
                    end
                    req = 3'b000;
                end else if (c == 5 || c == 7) begin
                    total++; if ({done, err} !== 4'b0) begin bad++; $display("FAIL to_err_c%0d: got %0h want 0", c, {done, err}); end
                end
            end
            total++; if (n_req != 5) begin bad++; $display("FAIL to_req_cycles: got %0d want 5", n_req); end
        end
`else
        begin
            int n_bad = 0;
            for (int c = 1; c <= 1000; c++) begin
                tick;
                if (mem_req !== 1'b1 || err !== 1'b0 || done !== 3'b000) n_bad++;
            end
            total++; if (n_bad != 0) begin bad++; $display("FAIL noto_hold: got %0d bad cycles want 0", n_bad); end
            mem_ack = 1'b1; mem_rdata = 8'h81;
            tick;
            mem_ack = 1'b0; req = 3'b000;
            total++; if ({done, err, rdata} !== {3'b001, 1'b0, 8'h81}) begin
                bad++; $display("FAIL noto_done: got %0h want %0h", {done, err, rdata}, {3'b001, 1'b0, 8'h81});
            end
        end
`endif
        tick;
    endtask

    initial begin
        test_reset;
        test_single_read;
        test_write_wait;
        test_contention;
        test_ack_ignored;
        test_reset_midop;
        test_timeout;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
